htif_req_queue: RTL



---
 rtl/htif_req_queue.sv | 75 +++++++
 1 files changed

// File: rtl/htif_req_queue.sv
// Ordered ready/valid request buffer between HTIF and the tile host port.
// Optional HTIF_QUEUE_PIPE_EN: accept a new word into a full queue when the head drains.
module htif_req_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [DATA_W-1:0]            enq_bits,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [DATA_W-1:0]            deq_bits,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [CW-1:0]     cnt;
  logic              full;
  logic              enq_fire;
  logic              deq_fire;

  // Explicit wrap keeps non-power-of-two depths in range.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full = (cnt == CW'(DEPTH));

`ifdef HTIF_QUEUE_PIPE_EN
  assign enq_ready = !full || deq_ready;
`else
  assign enq_ready = !full;
`endif

  assign deq_valid = (cnt != '0);
  assign deq_bits  = mem[rp];
  assign count     = cnt;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;

  always_ff @(posedge clk) begin
    if (enq_fire && !flush) begin
      mem[wp] <= enq_bits;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (enq_fire) wp <= nxt(wp);
      if (deq_fire) rp <= nxt(rp);
      unique case ({enq_fire, deq_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
